ps2_rx_fifo: RTL and testbench

//  PS/2 keyboard receiver feeding the SoC keyboard peripheral (Tetris controls).

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_byte_fifo.sv | 55 +++++
 rtl/ps2_rx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // Number of core clock cycles in the inter-edge timeout window (at least 1).
  function automatic int timeout_cycles(input longint clk_freq_hz, input longint timeout_us);
    longint cyc;
    cyc = (clk_freq_hz * timeout_us) / 1_000_000;
    if (cyc < 1) cyc = 1;
    return int'(cyc);
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small first-word-fall-through byte FIFO. The head byte is read straight
// from registered storage; pointers wrap naturally, occupancy is its own register.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Force the head to zero while empty so the output reads 0 after reset.
  assign dout  = empty ? 8'h00 : mem[rd_ptr];

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device->host receiver: pin synchronisers, clock glitch filter,
// frame deframer with inter-edge timeout, sticky error flags and a byte FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ps2_clk,
  input  logic                        i_ps2_data,
  output logic [7:0]                  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_parity_err,
  output logic                        o_frame_err,
  output logic                        o_overflow,
  input  logic                        i_clr_err
);

  localparam int TIMEOUT_CYC = timeout_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int FW          = $clog2(FILTER_LEN + 1);

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt_clk, filt_clk_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt;

  logic          start, shift_en, par_en, push_req, timeout;
  logic          perr_set, ferr_set, ovf_set;
  logic          push_q;
  logic [7:0]    push_byte;
  logic          pop;
  logic          fifo_full, fifo_empty;

  // Two-flop synchronisers; idle-high bus so they come out of reset at 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= i_ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= i_ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock filter: accept a new level only after FILTER_LEN consecutive samples of it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_clk_d & ~filt_clk;

  // Deframer state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Deframer next state and per-cycle actions; the timeout overrides everything.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    push_req = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    timeout  = (state_q != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));
    case (state_q)
      IDLE: begin
        // A fall with data high is line noise, not a start bit.
        if (fall && !dat_s2) begin
          start   = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_en  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d  = IDLE;
          push_req = dat_s2 && (^{shift_q, par_q});
          ferr_set = !dat_s2;
          perr_set = !(^{shift_q, par_q});
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d  = IDLE;
      ferr_set = 1'b1;
    end
  end

  // Bit counter and inter-edge timeout counter (counts cycles since the last fall).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (start)         bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (state_q == IDLE || fall || timeout) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + 1'b1;
    end
  end

  // Shift register (LSB first) and parity latch; pure datapath, no reset.
  always_ff @(posedge i_clk) begin
    if (start)         shift_q <= 8'h00;
    else if (shift_en) shift_q <= {dat_s2, shift_q[7:1]};
    if (par_en) par_q <= dat_s2;
    if (push_req) push_byte <= shift_q;
  end

  // One-cycle registered push toward the FIFO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) push_q <= 1'b0;
    else       push_q <= push_req;
  end

  assign pop     = o_valid && i_ready;
  assign o_valid = !fifo_empty;
  // A good byte is lost only when full and nothing leaves in the same cycle.
  assign ovf_set = push_q && fifo_full && !pop;

  // Sticky error flags; a new set beats a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_parity_err <= perr_set | (o_parity_err & ~i_clr_err);
      o_frame_err  <= ferr_set | (o_frame_err  & ~i_clr_err);
      o_overflow   <= ovf_set  | (o_overflow   & ~i_clr_err);
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push_q),
    .din   (push_byte),
    .pop   (pop),
    .dout  (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: drives PS/2 frames on the pins, queues expected bytes,
// and a monitor pops and compares on every handshake.
module tb_ps2_rx_fifo;

  localparam int CLK_FREQ_HZ = 25_000_000;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_US  = 20;
  localparam int FIFO_DEPTH  = 8;
  localparam int TO_CYC      = (CLK_FREQ_HZ / 1_000_000) * TIMEOUT_US;
  localparam int HALF        = 20;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    data;
  logic          valid;
  logic [CW-1:0] count;
  logic          perr, ferr, ovf;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_US  (TIMEOUT_US),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_count      (count),
    .o_parity_err (perr),
    .o_frame_err  (ferr),
    .o_overflow   (ovf),
    .i_clr_err    (clr_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Odd parity: the parity bit makes the count of ones in {byte,parity} odd.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Sends the first nbits of a frame; optional clock glitch in the high phase of bit
  // glitch_at; optional one-cycle ready pulse timed to coincide with the push.
  task automatic send_frame(input logic [10:0] fr, input int nbits, input int glitch_at,
                            input bit pop_at_push, output int lat);
    int cnt0;
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (i == glitch_at) begin
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 4 - (FILTER_LEN - 2));
      end else begin
        wait_cyc(HALF);
      end
      cnt0 = int'(count);
      ps2_clk = 1'b0;
      for (int c = 1; c <= HALF; c++) begin
        @(posedge clk); #1;
        if (i == nbits - 1) begin
          if (lat < 0 && int'(count) != cnt0) lat = c;
          if (pop_at_push && c == FILTER_LEN + 3) ready_mode = 1;
          if (pop_at_push && c == FILTER_LEN + 4) ready_mode = 0;
        end
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic good_frame(input logic [7:0] b);
    int lat;
    exp_q.push_back(b);
    send_frame(make_frame(b, 1'b0, 1'b0), 11, -1, 1'b0, lat);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    wait_cyc(1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) wait_cyc(1);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Ready driver: applied 2 time units after each edge, stable across the sampling edge.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every handshake pops the oldest expected byte and compares.
  initial forever begin
    @(negedge clk);
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h, expected no byte", data);
      end else begin
        check("pop_data", int'(data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int         lat;
    logic [7:0] b;
    logic [7:0] ovf_bytes[9];
    bit         bp, bs;

    // Reset state
    wait_cyc(3);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_count", count, 0);
    check("rst_perr", perr, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    wait_cyc(5);

    // 0x1C with consumer stalled: FIFO holds it; latency = 2 sync + filter + 2
    ready_mode = 0;
    exp_q.push_back(8'h1C);
    send_frame(make_frame(8'h1C, 1'b0, 1'b0), 11, -1, 1'b0, lat);
    check("lat_1c", lat, FILTER_LEN + 4);
    check("valid_1c", valid, 1);
    check("data_1c", data, 8'h1C);
    check("count_1c", count, 1);

    // F0 then 1C with consumer ready
    ready_mode = 1;
    good_frame(8'hF0);
    good_frame(8'h1C);
    drain();
    check("count_after_pops", count, 0);

    // Bad parity: no push, sticky parity error, cleared by pulse
    ready_mode = 0;
    send_frame(make_frame(8'h1C, 1'b1, 1'b0), 11, -1, 1'b0, lat);
    check("perr_set", perr, 1);
    check("perr_no_ferr", ferr, 0);
    check("perr_no_push", count, 0);
    pulse_clr();
    check("perr_cleared", perr, 0);

    // Overflow: 9 frames into 8 entries
    for (int i = 0; i < 9; i++) begin
      ovf_bytes[i] = 8'($urandom);
      if (i < FIFO_DEPTH) exp_q.push_back(ovf_bytes[i]);
      send_frame(make_frame(ovf_bytes[i], 1'b0, 1'b0), 11, -1, 1'b0, lat);
    end
    check("full_count", count, FIFO_DEPTH);
    check("ovf_set", ovf, 1);
    check("full_head", data, ovf_bytes[0]);
    pulse_clr();
    check("ovf_cleared", ovf, 0);
    // Push and pop together while full: both accepted, no overflow
    b = 8'($urandom);
    exp_q.push_back(b);
    send_frame(make_frame(b, 1'b0, 1'b0), 11, -1, 1'b1, lat);
    check("full_pushpop_count", count, FIFO_DEPTH);
    check("full_pushpop_no_ovf", ovf, 0);
    ready_mode = 1;
    drain();
    check("full_drained_count", count, 0);

    // Timeout: start + 4 bits, then idle
    ready_mode = 2;
    send_frame(make_frame(8'hA5, 1'b0, 1'b0), 5, -1, 1'b0, lat);
    wait_cyc(TO_CYC + 200);
    check("timeout_ferr", ferr, 1);
    check("timeout_no_perr", perr, 0);
    check("timeout_no_push", count, 0);
    pulse_clr();
    check("timeout_ferr_cleared", ferr, 0);
    good_frame(8'h29);
    drain();
    check("after_timeout_ferr", ferr, 0);

    // Short clock glitch mid-frame is filtered out
    exp_q.push_back(8'h5A);
    send_frame(make_frame(8'h5A, 1'b0, 1'b0), 11, 3, 1'b0, lat);
    drain();
    check("glitch_ferr", ferr, 0);
    check("glitch_perr", perr, 0);

    // Randomized frames with occasional parity/stop faults
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 7) == 0);
      if (!bp && !bs) exp_q.push_back(b);
      send_frame(make_frame(b, bp, bs), 11, -1, 1'b0, lat);
      check("rand_perr", perr, int'(bp));
      check("rand_ferr", ferr, int'(bs));
      if (bp || bs) pulse_clr();
    end
    drain();

    // Asynchronous reset mid-frame
    ready_mode = 0;
    good_frame(8'h33);
    send_frame(make_frame(8'h1C, 1'b1, 1'b0), 11, -1, 1'b0, lat);
    check("pre_rst_valid", valid, 1);
    check("pre_rst_perr", perr, 1);
    send_frame(make_frame(8'h6B, 1'b0, 1'b0), 4, -1, 1'b0, lat);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", valid, 0);
    check("async_rst_data", data, 0);
    check("async_rst_count", count, 0);
    check("async_rst_perr", perr, 0);
    check("async_rst_ferr", ferr, 0);
    check("async_rst_ovf", ovf, 0);
    exp_q.delete();
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(TO_CYC + 100);
    ready_mode = 2;
    good_frame(8'h77);
    drain();
    check("post_rst_ferr", ferr, 0);
    check("post_rst_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time guard so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout_guard: simulation did not complete, expected completion");
    $fatal(1, "time limit");
  end

endmodule
